stage_sequencer: RTL and testbench

Sequences the pixel-processing stages (y_pixel_filling and its siblings) one at a time over the single shared frame-RAM port. It enables each selected stage in order, waits for its done, and releases it. The active stage's wren/address/data_write are steered to the RAM, and the block reports overall completion to the top-level controller. It sits between the top-level control FSM and the RAM port.

---
 rtl/seq_pkg.sv | 24 ++
 rtl/stage_port_mux.sv | 32 +++
 rtl/stage_sequencer.sv | 137 +++++++++++++
 tb/tb_stage_sequencer.sv | 365 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_pkg.sv
// Shared types and defaults for the frame-RAM stage sequencer.
package seq_pkg;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      SELECT    = 3'd1,
      ENABLE    = 3'd2,
      WAIT_DONE = 3'd3,
      RELEASE   = 3'd4,
      FINISH    = 3'd5
   } seq_state_t;

   // Stage slot assignment on the shared RAM port; slot 0 runs first.
   typedef enum int unsigned {
      Y_FILL      = 0,
      X_FILL      = 1,
      DIAG_FILL   = 2,
      BORDER_FILL = 3
   } stage_slot_t;

   localparam int unsigned DEF_ADDR_WIDTH = 18;
   localparam int unsigned DEF_DATA_WIDTH = 32;

endpackage

// File: rtl/stage_port_mux.sv
// Zero-latency steering of the enabled stage's write port onto the frame RAM.
module stage_port_mux
   import seq_pkg::*;
#(
   parameter int unsigned NUM_STAGES = 4,
   parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH
) (
   input  logic [NUM_STAGES-1:0]            stage_enable,
   input  logic [NUM_STAGES-1:0]            stage_wren,
   input  logic [NUM_STAGES*ADDR_WIDTH-1:0] stage_address,
   input  logic [NUM_STAGES*DATA_WIDTH-1:0] stage_data_write,
   output logic                             wren,
   output logic [ADDR_WIDTH-1:0]            address,
   output logic [DATA_WIDTH-1:0]            data_write
);

   // Enable is one-hot or zero, so an AND-OR select is exact and idles at zero.
   always_comb begin
      wren       = 1'b0;
      address    = '0;
      data_write = '0;
      for (int unsigned k = 0; k < NUM_STAGES; k++) begin
         if (stage_enable[k]) begin
            wren       = wren | stage_wren[k];
            address    = address | stage_address[k*ADDR_WIDTH +: ADDR_WIDTH];
            data_write = data_write | stage_data_write[k*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

endmodule

// File: rtl/stage_sequencer.sv
// Runs the selected pixel-processing stages one at a time over the shared
// frame-RAM port and reports completion to the top-level controller.
module stage_sequencer
   import seq_pkg::*;
#(
   parameter int unsigned NUM_STAGES     = 4,
   parameter int unsigned ADDR_WIDTH     = DEF_ADDR_WIDTH,
   parameter int unsigned DATA_WIDTH     = DEF_DATA_WIDTH,
   parameter int unsigned TIMEOUT_CYCLES = 262143
) (
   input  logic                             clk_div_by_two,
   input  logic                             reset_n,
   input  logic                             pause,
   input  logic                             start_processing,
   input  logic [NUM_STAGES-1:0]            stage_mask,
   input  logic [NUM_STAGES-1:0]            stage_done,
   input  logic [NUM_STAGES-1:0]            stage_wren,
   input  logic [NUM_STAGES*ADDR_WIDTH-1:0] stage_address,
   input  logic [NUM_STAGES*DATA_WIDTH-1:0] stage_data_write,
   output logic [NUM_STAGES-1:0]            stage_enable,
   output logic                             wren,
   output logic [ADDR_WIDTH-1:0]            address,
   output logic [DATA_WIDTH-1:0]            data_write,
   output logic [$clog2(NUM_STAGES)-1:0]    current_stage,
   output logic                             busy,
   output logic                             processing_done,
   output logic                             timeout_error
);

   localparam int unsigned IDX_W = $clog2(NUM_STAGES + 1);
   localparam int unsigned CS_W  = $clog2(NUM_STAGES);
   localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

   seq_state_t            state;
   logic [IDX_W-1:0]      idx;
   logic [NUM_STAGES-1:0] mask_latched;
   logic [CNT_W-1:0]      timeout_cnt;

   logic [IDX_W-1:0]      idx_next;
   logic [CS_W-1:0]       idx_lo;
   logic [CS_W-1:0]       cs_next;

   // idx runs one past the last slot to mark the end; current_stage saturates.
   always_comb begin
      idx_next = idx + 1'b1;
      idx_lo   = idx[CS_W-1:0];
      cs_next  = (idx_next >= IDX_W'(NUM_STAGES)) ? CS_W'(NUM_STAGES - 1)
                                                  : idx_next[CS_W-1:0];
   end

   always_ff @(posedge clk_div_by_two or negedge reset_n) begin
      if (!reset_n) begin
         state           <= IDLE;
         idx             <= '0;
         mask_latched    <= '0;
         timeout_cnt     <= '0;
         stage_enable    <= '0;
         current_stage   <= '0;
         busy            <= 1'b0;
         processing_done <= 1'b0;
         timeout_error   <= 1'b0;
      end else if (!pause) begin
         case (state)
            IDLE: begin
               if (start_processing) begin
                  mask_latched  <= stage_mask;
                  busy          <= 1'b1;
                  timeout_error <= 1'b0;
                  idx           <= IDX_W'(Y_FILL);
                  current_stage <= CS_W'(Y_FILL);
                  state         <= SELECT;
               end
            end
            SELECT: begin
               if (idx == IDX_W'(NUM_STAGES)) begin
                  busy            <= 1'b0;
                  processing_done <= 1'b1;
                  current_stage   <= CS_W'(NUM_STAGES - 1);
                  state           <= FINISH;
               end else if (!mask_latched[idx_lo]) begin
                  idx           <= idx_next;
                  current_stage <= cs_next;
               end else begin
                  state <= ENABLE;
               end
            end
            ENABLE: begin
               stage_enable <= NUM_STAGES'(1) << idx_lo;
               timeout_cnt  <= '0;
               state        <= WAIT_DONE;
            end
            WAIT_DONE: begin
               if (stage_done[idx_lo]) begin
                  stage_enable <= '0;
                  state        <= RELEASE;
               end else if (timeout_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                  timeout_error <= 1'b1;
                  stage_enable  <= '0;
                  state         <= RELEASE;
               end else begin
                  timeout_cnt <= timeout_cnt + 1'b1;
               end
            end
            RELEASE: begin
               // Wait for the stage to drop done so it cannot leak into the next run.
               if (!stage_done[idx_lo]) begin
                  idx           <= idx_next;
                  current_stage <= cs_next;
                  state         <= SELECT;
               end
            end
            FINISH: begin
               if (!start_processing) begin
                  processing_done <= 1'b0;
                  state           <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   stage_port_mux #(
      .NUM_STAGES (NUM_STAGES),
      .ADDR_WIDTH (ADDR_WIDTH),
      .DATA_WIDTH (DATA_WIDTH)
   ) u_stage_port_mux (
      .stage_enable     (stage_enable),
      .stage_wren       (stage_wren),
      .stage_address    (stage_address),
      .stage_data_write (stage_data_write),
      .wren             (wren),
      .address          (address),
      .data_write       (data_write)
   );

endmodule

// File: tb/tb_stage_sequencer.sv
// Randomised bench for stage_sequencer with per-slot stage models and a run-level reference model.
module tb_stage_sequencer;

   localparam int NS = 4;
   localparam int AW = 18;
   localparam int DW = 32;
   localparam int TO = 16;

   logic             clk = 1'b0;
   logic             reset_n, pause, start;
   logic [NS-1:0]    stage_mask, stage_done, stage_wren, stage_enable;
   logic [NS*AW-1:0] stage_address;
   logic [NS*DW-1:0] stage_data_write;
   logic             wren;
   logic [AW-1:0]    address;
   logic [DW-1:0]    data_write;
   logic [1:0]       current_stage;
   logic             busy, processing_done, timeout_error;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   stage_sequencer #(
      .NUM_STAGES     (NS),
      .ADDR_WIDTH     (AW),
      .DATA_WIDTH     (DW),
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .clk_div_by_two   (clk),
      .reset_n          (reset_n),
      .pause            (pause),
      .start_processing (start),
      .stage_mask       (stage_mask),
      .stage_done       (stage_done),
      .stage_wren       (stage_wren),
      .stage_address    (stage_address),
      .stage_data_write (stage_data_write),
      .stage_enable     (stage_enable),
      .wren             (wren),
      .address          (address),
      .data_write       (data_write),
      .current_stage    (current_stage),
      .busy             (busy),
      .processing_done  (processing_done),
      .timeout_error    (timeout_error)
   );

   // Stage models: done rises after delay[k] unpaused enabled cycles, falls once
   // enable drops; delay 0 means done is already high when the stage is enabled.
   int          delay [NS] = '{10, 10, 10, 10};
   int          scnt  [NS];
   logic [NS-1:0] seen_en;

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         stage_done <= '0;
         seen_en    <= '0;
         for (int k = 0; k < NS; k++) scnt[k] <= 0;
      end else if (!pause) begin
         for (int k = 0; k < NS; k++) begin
            if (stage_enable[k]) begin
               scnt[k]    <= scnt[k] + 1;
               seen_en[k] <= 1'b1;
               if (scnt[k] + 1 >= delay[k]) stage_done[k] <= 1'b1;
            end else begin
               scnt[k] <= 0;
               if (!busy) seen_en[k] <= 1'b0;
               stage_done[k] <= (delay[k] == 0) && !seen_en[k] && busy;
            end
         end
      end
   end

   // Reference model: enabled slots in ascending order, each enabled for
   // min(delay+1, TO) unpaused cycles; a stage needing more than TO times out.
   int exp_sig;
   int exp_len [NS];
   bit exp_to;

   function automatic void model(input logic [NS-1:0] mask);
      exp_sig = 0;
      exp_to  = 0;
      for (int k = 0; k < NS; k++) begin
         exp_len[k] = 0;
         if (mask[k]) begin
            exp_sig    = exp_sig * 8 + k + 1;
            exp_len[k] = (delay[k] + 1 < TO) ? delay[k] + 1 : TO;
            if (delay[k] + 1 > TO) exp_to = 1;
         end
      end
   endfunction

   // Observations of one run.
   int         order_sig;
   int         hi_len [NS];
   int         overlap, mux_bad, cs_bad, pause_disturb;
   bit         run_timeout, done_busy, done_to, to_at_start, clear_ok, idle_busy, idle_to;
   logic [1:0] done_cs;

   task automatic do_run(input logic [NS-1:0] mask, input bit rnd_pause, input int pause_after);
      int            cyc, hi_total, n;
      bit            paused_done;
      logic [NS-1:0] prev_en, snap;
      logic          ew;
      logic [AW-1:0] ea;
      logic [DW-1:0] ed;
      order_sig = 0; overlap = 0; mux_bad = 0; cs_bad = 0; pause_disturb = 0;
      for (int k = 0; k < NS; k++) hi_len[k] = 0;
      cyc = 0; hi_total = 0; paused_done = 0; prev_en = '0;
      @(negedge clk);
      stage_mask = mask;
      start      = 1'b1;
      @(negedge clk);
      to_at_start = timeout_error;
      while (!processing_done && cyc < 2000) begin
         stage_wren       = NS'($urandom());
         stage_address    = (NS*AW)'({$urandom(), $urandom(), $urandom()});
         stage_data_write = {$urandom(), $urandom(), $urandom(), $urandom()};
         stage_mask       = NS'($urandom());
         if (busy) start = 1'($urandom_range(0, 1));
         if (pause_after != 0 && !paused_done && hi_total == pause_after) begin
            snap  = stage_enable;
            pause = 1'b1;
            repeat (20) begin
               @(negedge clk);
               if (stage_enable !== snap || busy !== 1'b1 || timeout_error !== 1'b0) pause_disturb++;
            end
            paused_done = 1;
            pause = 1'b0;
         end else begin
            pause = rnd_pause && ($urandom_range(0, 7) == 0);
         end
         #1;
         ew = 1'b0; ea = '0; ed = '0;
         for (int k = 0; k < NS; k++) begin
            if (stage_enable[k]) begin
               if (!prev_en[k]) order_sig = order_sig * 8 + k + 1;
               if (!pause) begin hi_len[k]++; hi_total++; end
               if (current_stage !== 2'(k)) cs_bad++;
               ew = stage_wren[k];
               ea = stage_address[k*AW +: AW];
               ed = stage_data_write[k*DW +: DW];
            end
         end
         if ($countones(stage_enable) > 1) overlap++;
         if (wren !== ew || address !== ea || data_write !== ed) mux_bad++;
         prev_en = stage_enable;
         @(negedge clk);
         cyc++;
      end
      pause       = 1'b0;
      run_timeout = (cyc >= 2000);
      done_busy   = busy;
      done_cs     = current_stage;
      done_to     = timeout_error;
      start       = 1'b0;
      n = 0;
      while (processing_done && n < 10) begin @(negedge clk); n++; end
      @(negedge clk);
      clear_ok  = !processing_done;
      idle_busy = busy;
      idle_to   = timeout_error;
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      checks++;
      if ({stage_enable, wren, address, data_write, current_stage, busy, processing_done, timeout_error} !== '0) begin
         errors++;
         $display("FAIL reset_outputs en=%b wren=%b addr=%0h data=%0h cs=%0d busy=%b done=%b to=%b required all zero",
                  stage_enable, wren, address, data_write, current_stage, busy, processing_done, timeout_error);
      end
      reset_n = 1'b1;
      repeat (2) @(negedge clk);
      checks++;
      if ({stage_enable, busy, processing_done, timeout_error} !== '0) begin
         errors++;
         $display("FAIL idle_after_reset en=%b busy=%b done=%b to=%b required all zero",
                  stage_enable, busy, processing_done, timeout_error);
      end
   endtask

   task automatic test_mask_0101();
      delay = '{10, 10, 10, 10};
      do_run(4'b0101, 1'b0, 0);
      model(4'b0101);
      checks++; if (run_timeout) begin errors++; $display("FAIL m0101_complete processing_done never rose"); end
      checks++; if (order_sig !== exp_sig) begin errors++; $display("FAIL m0101_order got=%0o exp=%0o", order_sig, exp_sig); end
      for (int k = 0; k < NS; k++) begin
         checks++; if (hi_len[k] !== exp_len[k]) begin errors++; $display("FAIL m0101_len slot%0d got=%0d exp=%0d", k, hi_len[k], exp_len[k]); end
      end
      checks++; if (overlap !== 0) begin errors++; $display("FAIL m0101_onehot overlap_cycles=%0d exp=0", overlap); end
      checks++; if (mux_bad !== 0 || cs_bad !== 0) begin errors++; $display("FAIL m0101_mux bad=%0d cs_bad=%0d exp=0", mux_bad, cs_bad); end
      checks++; if (done_busy !== 1'b0 || done_cs !== 2'd3 || done_to !== 1'b0) begin
         errors++; $display("FAIL m0101_finish busy=%b cs=%0d to=%b exp busy=0 cs=3 to=0", done_busy, done_cs, done_to);
      end
      checks++; if (!clear_ok || idle_busy) begin errors++; $display("FAIL m0101_idle clear=%b busy=%b exp clear=1 busy=0", clear_ok, idle_busy); end
   endtask

   task automatic test_mux();
      int k;
      delay = '{6, 0, 10, 10};
      stage_wren = 4'b0011;
      stage_address = '0;
      stage_address[0 +: AW] = 18'd2240;
      stage_address[AW +: AW] = 18'd12345;
      stage_data_write = '0;
      stage_data_write[0 +: DW] = 32'd1;
      stage_data_write[DW +: DW] = 32'hDEAD_BEEF;
      @(negedge clk);
      stage_mask = 4'b0001;
      start = 1'b1;
      @(negedge clk);
      #1;
      checks++; if (wren !== 1'b0 || address !== '0 || data_write !== '0) begin
         errors++; $display("FAIL mux_idle wren=%b addr=%0d data=%0h exp 0/0/0", wren, address, data_write);
      end
      k = 0;
      while (!stage_enable[0] && k < 20) begin @(negedge clk); k++; end
      #1;
      checks++; if (stage_enable !== 4'b0001 || wren !== 1'b1 || address !== 18'd2240 || data_write !== 32'd1) begin
         errors++; $display("FAIL mux_slot0 en=%b wren=%b addr=%0d data=%0h exp 0001/1/2240/1", stage_enable, wren, address, data_write);
      end
      stage_address[0 +: AW] = 18'd77;
      #1;
      checks++; if (address !== 18'd77) begin errors++; $display("FAIL mux_zero_latency addr=%0d exp=77", address); end
      stage_wren[0] = 1'b0;
      #1;
      checks++; if (wren !== 1'b0) begin errors++; $display("FAIL mux_disabled_wren wren=%b exp=0", wren); end
      stage_wren[0] = 1'b1;
      k = 0;
      while (!processing_done && k < 60) begin @(negedge clk); k++; end
      checks++; if (!processing_done) begin errors++; $display("FAIL mux_complete processing_done=%b exp=1", processing_done); end
      start = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_timeout();
      delay = '{5, 1000, 5, 5};
      do_run(4'b0111, 1'b0, 0);
      model(4'b0111);
      checks++; if (run_timeout) begin errors++; $display("FAIL to_complete processing_done never rose"); end
      checks++; if (order_sig !== exp_sig) begin errors++; $display("FAIL to_order got=%0o exp=%0o", order_sig, exp_sig); end
      for (int k = 0; k < NS; k++) begin
         checks++; if (hi_len[k] !== exp_len[k]) begin errors++; $display("FAIL to_len slot%0d got=%0d exp=%0d", k, hi_len[k], exp_len[k]); end
      end
      checks++; if (done_to !== exp_to) begin errors++; $display("FAIL to_flag got=%b exp=%b", done_to, exp_to); end
      checks++; if (idle_to !== 1'b1 || !clear_ok) begin errors++; $display("FAIL to_sticky to=%b clear=%b exp 1/1", idle_to, clear_ok); end
   endtask

   task automatic test_pause();
      delay = '{14, 10, 10, 10};
      do_run(4'b0001, 1'b0, 10);
      model(4'b0001);
      checks++; if (to_at_start !== 1'b0) begin errors++; $display("FAIL pause_to_cleared got=%b exp=0", to_at_start); end
      checks++; if (pause_disturb !== 0) begin errors++; $display("FAIL pause_frozen disturbed_cycles=%0d exp=0", pause_disturb); end
      checks++; if (hi_len[0] !== exp_len[0]) begin errors++; $display("FAIL pause_len got=%0d exp=%0d", hi_len[0], exp_len[0]); end
      checks++; if (done_to !== 1'b0 || run_timeout) begin errors++; $display("FAIL pause_no_timeout to=%b hung=%b exp 0/0", done_to, run_timeout); end
   endtask

   task automatic test_reset_midrun();
      int k;
      delay = '{30, 10, 10, 10};
      @(negedge clk);
      stage_mask = 4'b0001;
      stage_wren = '1;
      start = 1'b1;
      k = 0;
      while (!stage_enable[0] && k < 20) begin @(negedge clk); k++; end
      checks++; if (stage_enable !== 4'b0001) begin errors++; $display("FAIL rst_enable_rise en=%b exp=0001", stage_enable); end
      repeat (3) @(negedge clk);
      #2 reset_n = 1'b0;
      #1;
      checks++; if (stage_enable !== '0 || busy !== 1'b0 || wren !== 1'b0) begin
         errors++; $display("FAIL rst_async en=%b busy=%b wren=%b exp 0/0/0", stage_enable, busy, wren);
      end
      start = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      repeat (2) @(negedge clk);
      checks++; if (stage_enable !== '0 || busy !== 1'b0 || processing_done !== 1'b0) begin
         errors++; $display("FAIL rst_idle en=%b busy=%b done=%b exp 0/0/0", stage_enable, busy, processing_done);
      end
      delay[0] = 4;
      do_run(4'b0001, 1'b0, 0);
      model(4'b0001);
      checks++; if (order_sig !== exp_sig || hi_len[0] !== exp_len[0]) begin
         errors++; $display("FAIL rst_rerun order=%0o len=%0d exp order=%0o len=%0d", order_sig, hi_len[0], exp_sig, exp_len[0]);
      end
      checks++; if (run_timeout || done_to !== 1'b0 || !clear_ok) begin
         errors++; $display("FAIL rst_rerun_finish hung=%b to=%b clear=%b exp 0/0/1", run_timeout, done_to, clear_ok);
      end
   endtask

   task automatic test_mask_zero();
      int  cyc;
      bit  any_en, dropped;
      @(negedge clk);
      stage_mask = '0;
      start = 1'b1;
      cyc = 0; any_en = 0;
      while (!processing_done && cyc < 50) begin
         @(negedge clk);
         cyc++;
         if (stage_enable !== '0) any_en = 1;
      end
      checks++; if (cyc < NS + 1 || cyc > NS + 2) begin errors++; $display("FAIL m0_latency cycles=%0d exp %0d..%0d", cyc, NS + 1, NS + 2); end
      checks++; if (any_en) begin errors++; $display("FAIL m0_no_enable enable_seen=%b exp=0", any_en); end
      dropped = 0;
      repeat (5) begin @(negedge clk); if (processing_done !== 1'b1 || busy !== 1'b0) dropped = 1; end
      checks++; if (dropped) begin errors++; $display("FAIL m0_hold done fell or busy rose while start held, exp done=1 busy=0"); end
      start = 1'b0;
      @(negedge clk);
      checks++; if (processing_done !== 1'b0) begin errors++; $display("FAIL m0_clear done=%b exp=0", processing_done); end
      repeat (2) @(negedge clk);
      checks++; if (busy !== 1'b0 || processing_done !== 1'b0) begin errors++; $display("FAIL m0_idle busy=%b done=%b exp 0/0", busy, processing_done); end
   endtask

   task automatic test_random();
      logic [NS-1:0] mask;
      for (int r = 0; r < 12; r++) begin
         mask = NS'($urandom());
         for (int k = 0; k < NS; k++) delay[k] = $urandom_range(0, 20);
         do_run(mask, 1'b1, 0);
         model(mask);
         checks++; if (run_timeout) begin errors++; $display("FAIL rnd%0d_complete mask=%b hung", r, mask); end
         checks++; if (order_sig !== exp_sig) begin errors++; $display("FAIL rnd%0d_order mask=%b got=%0o exp=%0o", r, mask, order_sig, exp_sig); end
         for (int k = 0; k < NS; k++) begin
            checks++; if (hi_len[k] !== exp_len[k]) begin
               errors++; $display("FAIL rnd%0d_len slot%0d delay=%0d got=%0d exp=%0d", r, k, delay[k], hi_len[k], exp_len[k]);
            end
         end
         checks++; if (done_to !== exp_to) begin errors++; $display("FAIL rnd%0d_timeout got=%b exp=%b", r, done_to, exp_to); end
         checks++; if (overlap !== 0 || mux_bad !== 0 || cs_bad !== 0) begin
            errors++; $display("FAIL rnd%0d_port overlap=%0d mux_bad=%0d cs_bad=%0d exp 0/0/0", r, overlap, mux_bad, cs_bad);
         end
         checks++; if (to_at_start !== 1'b0 || !clear_ok || done_cs !== 2'd3) begin
            errors++; $display("FAIL rnd%0d_handshake to_start=%b clear=%b cs=%0d exp 0/1/3", r, to_at_start, clear_ok, done_cs);
         end
      end
   endtask

   initial begin
      reset_n          = 1'b0;
      pause            = 1'b0;
      start            = 1'b0;
      stage_mask       = '0;
      stage_wren       = '0;
      stage_address    = '0;
      stage_data_write = '0;
      test_reset();
      test_mask_0101();
      test_mux();
      test_timeout();
      test_pause();
      test_reset_midrun();
      test_mask_zero();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
